// File: rtl/conv_mem_if.sv
// conv_mem_if: bundles the engine access bus and the host dump port of the
// layer-memory responder.
//   Engine side : busy, cwr/caddr_wr/cdata_wr, crd/caddr_rd -> cdata_rd, csel
//   Dump side   : dump_start/dump_sel/dump_ready -> dump_valid/addr/data/last/done
//   Debug       : wr_cnt_l0, wr_cnt_l1, err
// Modport 'slave' is the responder; 'master' is the engine/host side.
interface conv_mem_if #(
  parameter int DW = 20,
  parameter int AW = 12
);
  logic          busy;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;
  logic          dump_start;
  logic          dump_sel;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_last;
  logic          dump_done;
  logic [12:0]   wr_cnt_l0;
  logic [10:0]   wr_cnt_l1;
  logic [2:0]    err;

  modport master (
    output busy, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
           dump_start, dump_sel, dump_ready,
    input  cdata_rd, dump_valid, dump_addr, dump_data, dump_last, dump_done,
           wr_cnt_l0, wr_cnt_l1, err
  );

  modport slave (
    input  busy, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
           dump_start, dump_sel, dump_ready,
    output cdata_rd, dump_valid, dump_addr, dump_data, dump_last, dump_done,
           wr_cnt_l0, wr_cnt_l1, err
  );
endinterface

// File: rtl/conv_mem_responder.sv
// conv_mem_responder: owns the Layer 0 (conv+ReLU) and Layer 1 (max-pool)
// result banks of the convolution engine.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high (memory contents are kept)
//   bus   : conv_mem_if.slave
//     - engine writes/reads select a bank with csel (1 = L0, 3 = L1);
//       cdata_rd is combinational, 0 unless a valid read is requested
//     - dump port streams a whole bank over valid/ready once busy is low
//     - wr_cnt_l0/l1 count accepted writes (saturating), err holds sticky
//       flags: [0] bad write, [1] bad read, [2] rejected dump_start
module conv_mem_responder #(
  parameter int DW       = 20,
  parameter int AW       = 12,
  parameter int L0_DEPTH = 4096,
  parameter int L1_DEPTH = 1024
) (
  input logic       clk,
  input logic       reset,
  conv_mem_if.slave bus
);

  localparam int L0_AW = $clog2(L0_DEPTH);
  localparam int L1_AW = $clog2(L1_DEPTH);

  localparam logic [2:0]    SEL_L0     = 3'd1;
  localparam logic [2:0]    SEL_L1     = 3'd3;
  localparam logic [12:0]   CNT_L0_MAX = 13'h1FFF;
  localparam logic [10:0]   CNT_L1_MAX = 11'h7FF;
  localparam logic [AW-1:0] L0_LAST    = AW'(L0_DEPTH - 1);
  localparam logic [AW-1:0] L1_LAST    = AW'(L1_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [DW-1:0] mem_l0_r [L0_DEPTH];
  logic [DW-1:0] mem_l1_r [L1_DEPTH];

  state_t        state_r;
  logic          bank_r;
  logic [AW-1:0] dump_addr_r;
  logic [DW-1:0] dump_data_r;
  logic          dump_valid_r;
  logic          dump_last_r;
  logic          dump_done_r;
  logic [12:0]   wr_cnt_l0_r;
  logic [10:0]   wr_cnt_l1_r;
  logic [2:0]    err_r;

  logic          wr_l0_s;
  logic          wr_l1_s;
  logic          wr_bad_s;
  logic          rd_bad_s;
  logic [DW-1:0] rd_data_s;
  logic          start_bad_s;
  logic [AW-1:0] load_addr_s;
  logic [DW-1:0] load_data_s;
  logic [AW-1:0] last_addr_s;

  // Write decode: which bank accepts the write, or whether it is dropped.
  always_comb begin
    wr_l0_s  = 1'b0;
    wr_l1_s  = 1'b0;
    wr_bad_s = 1'b0;
    if (bus.cwr) begin
      case (bus.csel)
        SEL_L0:  wr_l0_s = 1'b1;
        SEL_L1: begin
          // L1 is only 1024 deep; an address beyond it is an engine bug.
          if (bus.caddr_wr[AW-1:L1_AW] == '0) begin
            wr_l1_s = 1'b1;
          end else begin
            wr_bad_s = 1'b1;
          end
        end
        default: wr_bad_s = 1'b1;
      endcase
    end else begin
      wr_bad_s = 1'b0;
    end
  end

  // Engine read port: combinational, zero unless a valid bank is read.
  always_comb begin
    rd_data_s = {DW{1'b0}};
    rd_bad_s  = 1'b0;
    if (bus.crd) begin
      case (bus.csel)
        SEL_L0:  rd_data_s = mem_l0_r[bus.caddr_rd[L0_AW-1:0]];
        SEL_L1:  rd_data_s = mem_l1_r[bus.caddr_rd[L1_AW-1:0]];
        default: rd_bad_s  = 1'b1;
      endcase
    end else begin
      rd_bad_s = 1'b0;
    end
  end

  // Dump read port: word 0 is loaded while dump_valid is still low, later
  // words are loaded from the address following the one just accepted.
  always_comb begin
    load_addr_s = dump_addr_r;
    if (dump_valid_r) begin
      load_addr_s = dump_addr_r + AW'(1);
    end else begin
      load_addr_s = dump_addr_r;
    end
    if (bank_r) begin
      load_data_s = mem_l1_r[load_addr_s[L1_AW-1:0]];
      last_addr_s = L1_LAST;
    end else begin
      load_data_s = mem_l0_r[load_addr_s[L0_AW-1:0]];
      last_addr_s = L0_LAST;
    end
    start_bad_s = bus.dump_start & (bus.busy | (state_r != ST_IDLE));
  end

  // Bank storage: no reset so results survive a soft restart of the engine.
  always_ff @(posedge clk) begin
    if (wr_l0_s) begin
      mem_l0_r[bus.caddr_wr[L0_AW-1:0]] <= bus.cdata_wr;
    end
    if (wr_l1_s) begin
      mem_l1_r[bus.caddr_wr[L1_AW-1:0]] <= bus.cdata_wr;
    end
  end

  // Saturating write counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_l0_r <= 13'd0;
      wr_cnt_l1_r <= 11'd0;
      err_r       <= 3'b000;
    end else begin
      if (wr_l0_s && (wr_cnt_l0_r != CNT_L0_MAX)) begin
        wr_cnt_l0_r <= wr_cnt_l0_r + 13'd1;
      end
      if (wr_l1_s && (wr_cnt_l1_r != CNT_L1_MAX)) begin
        wr_cnt_l1_r <= wr_cnt_l1_r + 11'd1;
      end
      err_r <= err_r | {start_bad_s, rd_bad_s, wr_bad_s};
    end
  end

  // Dump FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      bank_r       <= 1'b0;
      dump_addr_r  <= {AW{1'b0}};
      dump_data_r  <= {DW{1'b0}};
      dump_valid_r <= 1'b0;
      dump_last_r  <= 1'b0;
      dump_done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          dump_done_r <= 1'b0;
          if (bus.dump_start && !bus.busy) begin
            state_r      <= ST_DUMP;
            bank_r       <= bus.dump_sel;
            dump_addr_r  <= {AW{1'b0}};
            dump_valid_r <= 1'b0;
            dump_last_r  <= 1'b0;
          end
        end
        ST_DUMP: begin
          if (!dump_valid_r) begin
            // First cycle in DUMP: present word 0.
            dump_valid_r <= 1'b1;
            dump_data_r  <= load_data_s;
            dump_last_r  <= (load_addr_s == last_addr_s);
          end else if (bus.dump_ready) begin
            if (dump_last_r) begin
              state_r      <= ST_DONE;
              dump_valid_r <= 1'b0;
              dump_last_r  <= 1'b0;
              dump_done_r  <= 1'b1;
            end else begin
              dump_addr_r <= load_addr_s;
              dump_data_r <= load_data_s;
              dump_last_r <= (load_addr_s == last_addr_s);
            end
          end
        end
        ST_DONE: begin
          dump_done_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          dump_valid_r <= 1'b0;
          dump_last_r  <= 1'b0;
          dump_done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cdata_rd   = rd_data_s;
  assign bus.dump_valid = dump_valid_r;
  assign bus.dump_addr  = dump_addr_r;
  assign bus.dump_data  = dump_data_r;
  assign bus.dump_last  = dump_last_r;
  assign bus.dump_done  = dump_done_r;
  assign bus.wr_cnt_l0  = wr_cnt_l0_r;
  assign bus.wr_cnt_l1  = wr_cnt_l1_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_conv_mem_responder.sv
// Testbench for conv_mem_responder: a reference model (two arrays, write
// counts and error flags) predicts every engine read and every dump word;
// expected values are queued at issue time and a negedge monitor compares
// them whenever the DUT presents a read or a dump handshake.
module tb_conv_mem_responder;

  typedef struct {
    logic [11:0] a;
    logic [19:0] d;
    logic        l;
  } dword_t;

  logic clk;
  logic reset;

  conv_mem_if #(.DW(20), .AW(12)) bus ();

  conv_mem_responder #(
    .DW(20), .AW(12), .L0_DEPTH(4096), .L1_DEPTH(1024)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference model state.
  logic [19:0] m0 [4096];
  logic [19:0] m1 [1024];
  int          exp_cnt0;
  int          exp_cnt1;
  logic [2:0]  exp_err;

  logic [19:0] rd_q[$];
  dword_t      dump_q[$];

  int   checks;
  int   errors;
  int   cyc;
  int   hs_count;
  int   done_cyc;
  bit   done_seen;
  bit   expect_done;
  bit   stall_v;
  dword_t held;
  bit   ready_mode;
  logic [3:0] rdy_pat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Host ready: always high, or the repeating 1,0,0,1 pattern.
  always @(posedge clk) begin
    #1;
    if (ready_mode) bus.dump_ready = rdy_pat[cyc % 4];
    else            bus.dump_ready = 1'b1;
  end

  // Monitor: compares reads and dump handshakes against the queued expectations.
  always @(negedge clk) begin
    if (reset) begin
      rd_q.delete();
      dump_q.delete();
      stall_v     = 1'b0;
      expect_done = 1'b0;
    end else begin
      if (bus.crd) begin
        if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else check("cdata_rd", {12'd0, bus.cdata_rd}, {12'd0, rd_q.pop_front()});
      end
      if (expect_done) begin
        check("dump_done_pulse", {31'd0, bus.dump_done}, 32'd1);
        expect_done = 1'b0;
      end else if (bus.dump_done) begin
        check("done_spurious", 32'd1, 32'd0);
      end
      if (bus.dump_done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (stall_v) begin
        check("stall_addr", {20'd0, bus.dump_addr}, {20'd0, held.a});
        check("stall_data", {12'd0, bus.dump_data}, {12'd0, held.d});
        check("stall_last", {31'd0, bus.dump_last}, {31'd0, held.l});
      end
      if (bus.dump_valid && bus.dump_ready) begin
        if (dump_q.size() == 0) begin
          check("dump_extra", 32'd1, 32'd0);
        end else begin
          dword_t e;
          e = dump_q.pop_front();
          check("dump_addr", {20'd0, bus.dump_addr}, {20'd0, e.a});
          check("dump_data", {12'd0, bus.dump_data}, {12'd0, e.d});
          check("dump_last", {31'd0, bus.dump_last}, {31'd0, e.l});
          if (e.l) expect_done = 1'b1;
        end
        hs_count = hs_count + 1;
      end
      stall_v = bus.dump_valid && !bus.dump_ready;
      held.a  = bus.dump_addr;
      held.d  = bus.dump_data;
      held.l  = bus.dump_last;
    end
  end

  // One engine cycle: drive, predict from the model, then advance one edge.
  task automatic eng(input bit wr, input bit rd, input logic [2:0] sel,
                     input logic [11:0] waddr, input logic [19:0] wdata,
                     input logic [11:0] raddr);
    logic [19:0] exp_rd;
    bus.cwr = wr; bus.crd = rd; bus.csel = sel;
    bus.caddr_wr = waddr; bus.cdata_wr = wdata; bus.caddr_rd = raddr;
    if (rd) begin
      if (sel == 3'd1)      exp_rd = m0[raddr];
      else if (sel == 3'd3) exp_rd = m1[raddr % 1024];
      else begin
        exp_rd     = 20'd0;
        exp_err[1] = 1'b1;
      end
      rd_q.push_back(exp_rd);
    end
    if (wr) begin
      if (sel == 3'd1) begin
        m0[waddr] = wdata;
        if (exp_cnt0 < 8191) exp_cnt0++;
      end else if (sel == 3'd3 && waddr < 12'd1024) begin
        m1[waddr % 1024] = wdata;
        if (exp_cnt1 < 2047) exp_cnt1++;
      end else begin
        exp_err[0] = 1'b1;
      end
    end
    @(posedge clk); #1;
    bus.cwr = 1'b0;
    bus.crd = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt0  = 0;
    exp_cnt1  = 0;
    exp_err   = 3'b000;
    done_seen = 1'b0;
  endtask

  task automatic check_cnt_err(input string tag);
    check({tag, "_cnt_l0"}, {19'd0, bus.wr_cnt_l0}, exp_cnt0);
    check({tag, "_cnt_l1"}, {21'd0, bus.wr_cnt_l1}, exp_cnt1);
    check({tag, "_err"}, {29'd0, bus.err}, {29'd0, exp_err});
  endtask

  // Queue the whole bank from the model, pulse dump_start, check start latency.
  task automatic start_dump(input bit sel, output int first_cyc);
    int depth;
    depth = sel ? 1024 : 4096;
    for (int i = 0; i < depth; i++) begin
      dword_t w;
      w.a = 12'(i);
      w.d = sel ? m1[i] : m0[i];
      w.l = (i == depth - 1);
      dump_q.push_back(w);
    end
    hs_count  = 0;
    done_seen = 1'b0;
    bus.dump_sel   = sel;
    bus.dump_start = 1'b1;
    @(posedge clk); #1;
    bus.dump_start = 1'b0;
    check("lat_valid_n", {31'd0, bus.dump_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_valid_n1", {31'd0, bus.dump_valid}, 32'd1);
    check("lat_addr0", {20'd0, bus.dump_addr}, 32'd0);
    first_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, input int depth);
    for (int n = 0; n < budget && !done_seen; n++) begin
      @(posedge clk); #1;
    end
    check("dump_finished", {31'd0, done_seen}, 32'd1);
    check("dump_words", hs_count, depth);
    check("dump_q_empty", dump_q.size(), 32'd0);
  endtask

  initial begin
    int first_cyc;
    logic [2:0] sels [6];
    checks = 0; errors = 0; cyc = 0; hs_count = 0;
    done_seen = 1'b0; expect_done = 1'b0; stall_v = 1'b0;
    ready_mode = 1'b0; rdy_pat = 4'b1001;
    sels[0] = 3'd1; sels[1] = 3'd3; sels[2] = 3'd1;
    sels[3] = 3'd3; sels[4] = 3'd0; sels[5] = 3'd2;
    bus.busy = 1'b0; bus.cwr = 1'b0; bus.crd = 1'b0; bus.csel = 3'd0;
    bus.caddr_wr = 12'd0; bus.cdata_wr = 20'd0; bus.caddr_rd = 12'd0;
    bus.dump_start = 1'b0; bus.dump_sel = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_dut();

    // Reset values.
    check("rst_valid", {31'd0, bus.dump_valid}, 32'd0);
    check("rst_last",  {31'd0, bus.dump_last},  32'd0);
    check("rst_done",  {31'd0, bus.dump_done},  32'd0);
    check("rst_addr",  {20'd0, bus.dump_addr},  32'd0);
    check("rst_data",  {12'd0, bus.dump_data},  32'd0);
    check("rst_cdata_rd", {12'd0, bus.cdata_rd}, 32'd0);
    check_cnt_err("rst");

    // Fill both banks, then reset: contents must survive, counters clear.
    for (int i = 0; i < 4096; i++) eng(1'b1, 1'b0, 3'd1, 12'(i), 20'($urandom), 12'd0);
    for (int i = 0; i < 1024; i++) eng(1'b1, 1'b0, 3'd3, 12'(i), 20'($urandom), 12'd0);
    check_cnt_err("fill");
    reset_dut();

    // Directed engine accesses.
    eng(1'b1, 1'b0, 3'd1, 12'h041, 20'h01310, 12'd0);
    eng(1'b0, 1'b1, 3'd1, 12'd0, 20'd0, 12'h041);
    check_cnt_err("l0_wr");
    eng(1'b1, 1'b1, 3'd1, 12'h041, 20'h0ABCD, 12'h041);   // same-cycle read sees old
    eng(1'b0, 1'b1, 3'd1, 12'd0, 20'd0, 12'h041);
    eng(1'b1, 1'b0, 3'd3, 12'h3FF, 20'h7FFFF, 12'd0);
    eng(1'b0, 1'b1, 3'd3, 12'd0, 20'd0, 12'h3FF);
    eng(1'b0, 1'b1, 3'd1, 12'd0, 20'd0, 12'h3FF);
    check_cnt_err("l1_wr");
    eng(1'b1, 1'b0, 3'd3, 12'h400, 20'h12345, 12'd0);     // out of L1 range
    eng(1'b0, 1'b1, 3'd3, 12'd0, 20'd0, 12'h000);
    check_cnt_err("l1_oob");
    eng(1'b0, 1'b1, 3'd2, 12'd0, 20'd0, 12'h041);         // invalid read
    eng(1'b1, 1'b0, 3'd0, 12'h005, 20'h55555, 12'd0);     // invalid write
    eng(1'b0, 1'b1, 3'd1, 12'd0, 20'd0, 12'h005);
    check_cnt_err("bad_sel");

    // Randomized engine traffic.
    for (int i = 0; i < 400; i++) begin
      logic [11:0] wa;
      wa = 12'($urandom);
      if ($urandom_range(0, 3) == 0) wa = wa & 12'h3FF;
      eng(1'($urandom), 1'($urandom), sels[$urandom_range(0, 5)],
          wa, 20'($urandom), 12'($urandom));
    end
    check_cnt_err("rand");

    // L1 = address, streamed with ready high.
    for (int i = 0; i < 1024; i++) eng(1'b1, 1'b0, 3'd3, 12'(i), 20'(i), 12'd0);
    ready_mode = 1'b0;
    start_dump(1'b1, first_cyc);
    wait_done(1200, 1024);
    check("l1_dump_cycles", done_cyc - first_cyc, 32'd1024);
    check_cnt_err("l1_dump");

    // L0 with backpressure, plus a dump_start while streaming.
    reset_dut();
    ready_mode = 1'b1;
    start_dump(1'b0, first_cyc);
    repeat (50) begin @(posedge clk); #1; end
    bus.dump_sel = 1'b1; bus.dump_start = 1'b1;
    @(posedge clk); #1;
    bus.dump_start = 1'b0;
    exp_err[2] = 1'b1;
    wait_done(12000, 4096);
    check_cnt_err("l0_dump");
    ready_mode = 1'b0;

    // dump_start while busy is rejected.
    reset_dut();
    bus.busy = 1'b1; bus.dump_sel = 1'b0; bus.dump_start = 1'b1;
    @(posedge clk); #1;
    bus.dump_start = 1'b0;
    exp_err[2] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("busy_no_valid", {31'd0, bus.dump_valid}, 32'd0);
    check("busy_no_done", {31'd0, done_seen}, 32'd0);
    check_cnt_err("busy");
    bus.busy = 1'b0;

    // Reset in the middle of a dump.
    reset_dut();
    start_dump(1'b1, first_cyc);
    for (int n = 0; n < 400 && hs_count < 100; n++) @(negedge clk);
    @(posedge clk); #1;
    reset_dut();
    check("mid_rst_valid", {31'd0, bus.dump_valid}, 32'd0);
    check("mid_rst_addr",  {20'd0, bus.dump_addr},  32'd0);
    check("mid_rst_data",  {12'd0, bus.dump_data},  32'd0);
    check("mid_rst_last",  {31'd0, bus.dump_last},  32'd0);
    repeat (10) begin @(posedge clk); #1; end
    check("mid_rst_no_done", {31'd0, done_seen}, 32'd0);
    check_cnt_err("mid_rst");

    // Counter saturation.
    for (int i = 0; i < 8200; i++) eng(1'b1, 1'b0, 3'd1, 12'($urandom), 20'($urandom), 12'd0);
    for (int i = 0; i < 2050; i++) eng(1'b1, 1'b0, 3'd3, 12'($urandom_range(0, 1023)), 20'($urandom), 12'd0);
    check("sat_l0", {19'd0, bus.wr_cnt_l0}, 32'd8191);
    check("sat_l1", {21'd0, bus.wr_cnt_l1}, 32'd2047);
    for (int i = 0; i < 20; i++) eng(1'b0, 1'b1, sels[$urandom_range(0, 1)], 12'd0, 20'd0, 12'($urandom));
    check_cnt_err("sat");

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_mem_responder.md
# conv_mem_responder

Layer-memory responder for the convolution engine's result interface: owns the Layer 0 (conv+ReLU, 64x64) and Layer 1 (max-pool, 32x32) result banks. It services `cwr`/`crd` accesses selected by `csel`, and once the engine drops `busy` it streams either bank to the host over a valid/ready dump port. Sticky error flags and per-bank write counters support verification.

## Interface
- `DW`, 20, data width of result words (signed fixed point, 4.16)
- `AW`, 12, engine address width
- `L0_DEPTH`, 4096, Layer 0 words
- `L1_DEPTH`, 1024, Layer 1 words
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `busy`  in  1  engine busy; dump allowed only when low
- `cwr`  in  1  write strobe
- `caddr_wr`  in  AW  write address
- `cdata_wr`  in  DW  write data
- `crd`  in  1  read strobe
- `caddr_rd`  in  AW  read address
- `cdata_rd`  out  DW  read data
- `csel`  in  3  bank select: 3'd1 = L0, 3'd3 = L1, others invalid
- `dump_start`  in  1  one-cycle request to stream a bank
- `dump_sel`  in  1  0 = L0, 1 = L1; sampled with `dump_start`
- `dump_valid`  out  1  dump word valid
- `dump_ready`  in  1  host accepts word
- `dump_addr`  out  AW  address of current dump word
- `dump_data`  out  DW  current dump word
- `dump_last`  out  1  high with final word of the bank
- `dump_done`  out  1  one-cycle pulse after final handshake
- `wr_cnt_l0`  out  13  L0 writes since reset, saturating at 8191
- `wr_cnt_l1`  out  11  L1 writes since reset, saturating at 2047
- `err`  out  3  sticky error flags

## Operation
- Writes: on an edge with `cwr`=1, `mem[csel][caddr_wr] <= cdata_wr`.
  - For L1, only `caddr_wr[9:0]` is used; a nonzero `caddr_wr[11:10]` sets `err[0]` and the write is dropped.
  - If `csel` is not 1 or 3, the write is dropped and `err[0]` is set.
  - Each accepted write increments its bank counter, including rewrites of the same address.
- Reads: `cdata_rd` is combinational: when `crd`=1 and `csel` is valid, it is the stored word at `caddr_rd` (L1 uses `[9:0]`); otherwise 0.
  - A read with `crd`=1 and invalid `csel` sets `err[1]`.
- Read-after-write: a word written at edge N is visible on `cdata_rd` from the cycle after edge N. A same-cycle read of the address being written returns the old value.
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE→DUMP: `dump_start`=1 and `busy`=0. The start address counter loads 0 and the bank is latched from `dump_sel`.
  - `dump_start` while `busy`=1, or while in DUMP/DONE, is ignored and sets `err[2]`.
  - DUMP: `dump_valid`=1. `dump_data`/`dump_addr` are registered and held stable until `dump_valid & dump_ready`. On each handshake the address increments and the next word loads.
  - `dump_last`=1 when `dump_addr` = depth−1 of the latched bank. A handshake on the last word → DONE.
  - DONE: `dump_done`=1 for exactly one cycle, `dump_valid`=0, then → IDLE.
  - The dump uses a dedicated read port, so engine accesses during a dump proceed normally. A dump word reflects memory contents at the edge it was loaded.
- Memory contents are not cleared by reset.

## Timing
- Reset values: `dump_valid`=0, `dump_last`=0, `dump_done`=0, `dump_addr`=0, `dump_data`=0, `wr_cnt_l0`=0, `wr_cnt_l1`=0, `err`=0, FSM=IDLE. `cdata_rd` is combinational (0 while `crd`=0).
- Reset asserted mid-dump: next edge returns to IDLE with all dump outputs at reset values and no `dump_done`.
- Dump latency:
  - `dump_start` sampled at edge N → `dump_valid`=1 with word 0 after edge N+1.
  - With `dump_ready` tied high: one word per cycle; L0 takes 4096 cycles, L1 takes 1024.
  - `dump_done` is high in the cycle following the last handshake.
- Backpressure: `dump_ready`=0 freezes `dump_addr`, `dump_data` and `dump_last` unchanged.
- Counter saturation: a counter at maximum stays at maximum. Counters and `err` update on the same edge as the triggering access.

## Test plan
- Write L0[0x041]=0x01310 (`csel`=1), next cycle read with `crd`=1, `csel`=1, `caddr_rd`=0x041 → `cdata_rd`=0x01310; `wr_cnt_l0`=1.
- Write L1[0x3FF]=0x7FFFF (`csel`=3) → read returns 0x7FFFF; L0[0x3FF] unchanged; `wr_cnt_l1`=1. Write with `csel`=3, `caddr_wr`=0x400 → dropped, `err`=3'b001.
- Read with `csel`=2, `crd`=1 → `cdata_rd`=0, `err[1]`=1. Write with `csel`=0 → no memory change, `err[0]`=1.
- Fill L1 with value = address, `busy`=0, pulse `dump_start` with `dump_sel`=1 and `dump_ready` high → 1024 words 0..1023 in order, `dump_last` on addr 0x3FF, `dump_done` one cycle later.
- Dump L0 with `dump_ready` toggling 1,0,0,1 → no word skipped or duplicated, data stable while stalled. `dump_start` while `busy`=1 → ignored, `err[2]`=1. Reset at word 100 → `dump_valid`=0 next cycle, no `dump_done`.
